gouram_wb_tracker: RTL and testbench

Parametrised writeback-phase tracker for the Gouram trace pipeline, the next generation of the single-element WB tracker. It sits between the EX tracker and the trace output stage. It accepts trace elements over a valid/ready handshake, buffers them, and timestamps writeback and memory-response windows from a recorded event history. It adds configurable depths and counter width, output backpressure, wrap-safe time arithmetic and an overflow flag.

---
 rtl/gouram_trace_pkg.sv | 39 +++
 rtl/gouram_sync_fifo.sv | 49 ++++
 rtl/gouram_wb_tracker.sv | 150 +++++++++++++++
 tb/tb_gouram_wb_tracker.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared types for the Gouram trace pipeline: the trace element, the WB tracker
// state encoding and wrap-safe timestamp helpers.
package gouram_trace_pkg;

    localparam int TIME_W_MAX = 32;

    typedef logic [TIME_W_MAX-1:0] time_t;

    typedef struct packed {
        logic  pass_through;
        logic  is_mem;
        time_t ex_time_end;
        time_t mem_req_time_end;
        time_t wb_time_start;
        time_t wb_time_end;
        time_t res_time_start;
        time_t res_time_end;
    } wb_trace_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEARCH,
        ST_EMIT
    } wb_state_t;

    function automatic time_t time_mask(input int w);
        if (w >= TIME_W_MAX) return '1;
        return (time_t'(1) << w) - time_t'(1);
    endfunction

    // True when ev_time is strictly after thr, treating the w-bit difference as signed.
    function automatic logic time_later(input time_t ev_time, input time_t thr, input int w);
        time_t diff;
        diff = (ev_time - thr) & time_mask(w);
        return (diff != '0) && ((diff & (time_t'(1) << (w - 1))) == '0);
    endfunction

endpackage

// File: rtl/gouram_sync_fifo.sv
// Single-clock FIFO with combinational head read; push and pop in the same
// cycle are accepted even when full.
module gouram_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/gouram_wb_tracker.sv
// Writeback-phase tracker: buffers EX trace elements and timestamps them from a
// recorded WB/memory event history. GOURAM_WB_STALL_COUNT_EN adds wb_stall_o.
module gouram_wb_tracker
    import gouram_trace_pkg::*;
#(
    parameter int TIME_W      = 32,
    parameter int TRACE_DEPTH = 32,
    parameter int EVT_DEPTH   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [TIME_W-1:0] counter,
    input  logic              ex_valid_i,
    output logic              ex_ready_o,
    input  wb_trace_t         ex_data_i,
    input  logic              wb_ready,
    input  logic              data_mem_rvalid,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output wb_trace_t         wb_data_o,
    output logic [TIME_W-1:0] previous_end_o,
    output logic              evt_overflow_o,
`ifdef GOURAM_WB_STALL_COUNT_EN
    output logic [15:0]       wb_stall_o,
`endif
    output wb_state_t         state_o
);
    // Both handshakes transfer on a cycle where valid && ready; once valid is
    // raised, data is held stable until the transfer happens.
    localparam int    TRACE_W = $bits(wb_trace_t);
    localparam int    EVT_W   = TIME_W + 2;
    localparam time_t TMASK   = time_mask(TIME_W);

    wb_state_t          state, state_n;
    wb_trace_t          cur, cur_n;
    logic [TIME_W-1:0]  prev_end;
    logic               overflow;

    logic               trace_pop, trace_full, trace_empty;
    logic [TRACE_W-1:0] trace_dout;
    logic               evt_push, evt_pop, evt_full, evt_empty;
    logic [EVT_W-1:0]   evt_din, evt_dout;

    time_t              ev_time, thr, mem_start;
    logic               ev_wb, ev_rvalid, ev_later;

    assign evt_push = wb_ready || data_mem_rvalid;
    assign evt_din  = {counter, wb_ready, data_mem_rvalid};

    gouram_sync_fifo #(.WIDTH(TRACE_W), .DEPTH(TRACE_DEPTH)) u_trace_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ex_valid_i && ex_ready_o),
        .din   (ex_data_i),
        .pop   (trace_pop),
        .dout  (trace_dout),
        .full  (trace_full),
        .empty (trace_empty)
    );

    gouram_sync_fifo #(.WIDTH(EVT_W), .DEPTH(EVT_DEPTH)) u_evt_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (evt_push),
        .din   (evt_din),
        .pop   (evt_pop),
        .dout  (evt_dout),
        .full  (evt_full),
        .empty (evt_empty)
    );

    assign ev_time   = TIME_W_MAX'(evt_dout[EVT_W-1:2]);
    assign ev_wb     = evt_dout[1];
    assign ev_rvalid = evt_dout[0];
    assign thr       = cur.is_mem ? cur.mem_req_time_end : cur.ex_time_end;
    assign ev_later  = time_later(ev_time, thr, TIME_W);
    assign mem_start = (cur.mem_req_time_end + time_t'(1)) & TMASK;

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        trace_pop  = 1'b0;
        evt_pop    = 1'b0;
        wb_valid_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!trace_empty) begin
                    trace_pop = 1'b1;
                    cur_n     = wb_trace_t'(trace_dout);
                    state_n   = ST_LOAD;
                end
            end
            ST_LOAD: state_n = cur.pass_through ? ST_EMIT : ST_SEARCH;
            ST_SEARCH: begin
                // Every examined event is consumed, matching or not.
                if (!evt_empty) begin
                    evt_pop = 1'b1;
                    if (ev_later && cur.is_mem && ev_rvalid) begin
                        cur_n.wb_time_start  = mem_start;
                        cur_n.res_time_start = mem_start;
                        cur_n.wb_time_end    = ev_time;
                        cur_n.res_time_end   = ev_time;
                        state_n              = ST_EMIT;
                    end else if (ev_later && !cur.is_mem && ev_wb) begin
                        cur_n.wb_time_start  = ev_time;
                        cur_n.wb_time_end    = ev_time;
                        cur_n.res_time_start = '0;
                        cur_n.res_time_end   = '0;
                        state_n              = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                wb_valid_o = 1'b1;
                if (wb_ready_i) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            cur      <= '0;
            prev_end <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_n;
            cur   <= cur_n;
            if (state == ST_EMIT && wb_ready_i && !cur.pass_through)
                prev_end <= cur.wb_time_end[TIME_W-1:0];
            if (evt_push && evt_full && !evt_pop)
                overflow <= 1'b1;
        end
    end

    assign ex_ready_o     = !trace_full;
    assign wb_data_o      = cur;
    assign previous_end_o = prev_end;
    assign evt_overflow_o = overflow;
    assign state_o        = state;

`ifdef GOURAM_WB_STALL_COUNT_EN
    time_t stall_raw;
    assign stall_raw  = (cur.wb_time_end - cur.ex_time_end - time_t'(1)) & TMASK;
    assign wb_stall_o = cur.pass_through ? 16'h0000 :
                        (stall_raw > time_t'(32'h0000_FFFF)) ? 16'hFFFF : stall_raw[15:0];
`endif

endmodule

// File: tb/tb_gouram_wb_tracker.sv
// Directed bench for gouram_wb_tracker: a 32-bit instance for the main scenarios
// and an 8-bit instance for timestamp wrap-around.
module tb_gouram_wb_tracker;
    import gouram_trace_pkg::*;

    localparam int TRACE_DEPTH = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [31:0] counter;
    logic        ex_valid, ex_ready, wb_ready, rvalid, wb_valid, dn_ready, ovf;
    wb_trace_t   ex_data, wb_data;
    logic [31:0] prev_end;
    wb_state_t   state;

    logic [7:0]  counter8, prev_end8;
    logic        ex_valid8, ex_ready8, wb_ready8, rvalid8, wb_valid8, dn_ready8, ovf8;
    wb_trace_t   wb_data8;
    wb_state_t   state8;
`ifdef GOURAM_WB_STALL_COUNT_EN
    logic [15:0] stall, stall8;
`endif

    int checks = 0;
    int errors = 0;

    gouram_wb_tracker #(.TIME_W(32), .TRACE_DEPTH(TRACE_DEPTH), .EVT_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .counter(counter),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_data_i(ex_data),
        .wb_ready(wb_ready), .data_mem_rvalid(rvalid),
        .wb_valid_o(wb_valid), .wb_ready_i(dn_ready), .wb_data_o(wb_data),
        .previous_end_o(prev_end), .evt_overflow_o(ovf),
`ifdef GOURAM_WB_STALL_COUNT_EN
        .wb_stall_o(stall),
`endif
        .state_o(state)
    );

    gouram_wb_tracker #(.TIME_W(8), .TRACE_DEPTH(TRACE_DEPTH), .EVT_DEPTH(16)) dut8 (
        .clk(clk), .rst(rst), .counter(counter8),
        .ex_valid_i(ex_valid8), .ex_ready_o(ex_ready8), .ex_data_i(ex_data),
        .wb_ready(wb_ready8), .data_mem_rvalid(rvalid8),
        .wb_valid_o(wb_valid8), .wb_ready_i(dn_ready8), .wb_data_o(wb_data8),
        .previous_end_o(prev_end8), .evt_overflow_o(ovf8),
`ifdef GOURAM_WB_STALL_COUNT_EN
        .wb_stall_o(stall8),
`endif
        .state_o(state8)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    function automatic wb_trace_t mk(input logic pt, input logic mem,
                                     input logic [31:0] ex_end, input logic [31:0] req_end);
        wb_trace_t e;
        e                  = '0;
        e.pass_through     = pt;
        e.is_mem           = mem;
        e.ex_time_end      = ex_end;
        e.mem_req_time_end = req_end;
        return e;
    endfunction

    task automatic do_reset();
        rst = 1'b0; counter = '0; ex_valid = 1'b0; ex_data = '0;
        wb_ready = 1'b0; rvalid = 1'b0; dn_ready = 1'b0;
        counter8 = '0; ex_valid8 = 1'b0; wb_ready8 = 1'b0; rvalid8 = 1'b0; dn_ready8 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_elem(input wb_trace_t e);
        ex_data  = e;
        ex_valid = 1'b1;
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic pulse_evt(input logic [31:0] t, input logic wbr, input logic rv);
        counter  = t;
        wb_ready = wbr;
        rvalid   = rv;
        @(negedge clk);
        wb_ready = 1'b0;
        rvalid   = 1'b0;
    endtask

    task automatic accept();
        dn_ready = 1'b1;
        @(negedge clk);
        dn_ready = 1'b0;
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n;
        n = 0;
        while (wb_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (wb_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s: wb_valid=%b after %0d cycles, expected 1", name, wb_valid, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b, expected 1", ex_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b, expected 0", wb_valid); end
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL reset_wb_data: got %h, expected 0", wb_data); end
        checks++; if (prev_end !== 32'd0) begin errors++; $display("FAIL reset_prev_end: got %0d, expected 0", prev_end); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", ovf); end
        checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, expected %0d", state, ST_IDLE); end
    endtask

    task automatic test_pass_through();
        wb_trace_t e;
        e = mk(1'b1, 1'b0, 32'd55, 32'd0);
        e.wb_time_start = 32'd7;
        e.wb_time_end   = 32'd9;
        e.res_time_end  = 32'd11;
        push_elem(e);
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL pt_early: wb_valid=%b, expected 0", wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL pt_latency: wb_valid=%b, expected 1", wb_valid); end
        checks++; if (wb_data !== e) begin errors++; $display("FAIL pt_data: got %h, expected %h", wb_data, e); end
        accept();
        checks++; if (prev_end !== 32'd0) begin errors++; $display("FAIL pt_prev_end: got %0d, expected 0", prev_end); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL pt_drop: wb_valid=%b, expected 0", wb_valid); end
    endtask

    task automatic test_non_mem();
        push_elem(mk(1'b0, 1'b0, 32'd100, 32'd0));
        pulse_evt(32'd98, 1'b1, 1'b0);
        pulse_evt(32'd103, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL nm_skip_early: wb_valid=%b, expected 0", wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL nm_latency: wb_valid=%b, expected 1", wb_valid); end
        checks++; if (wb_data.wb_time_start !== 32'd103) begin errors++; $display("FAIL nm_wb_start: got %0d, expected 103", wb_data.wb_time_start); end
        checks++; if (wb_data.wb_time_end !== 32'd103) begin errors++; $display("FAIL nm_wb_end: got %0d, expected 103", wb_data.wb_time_end); end
        checks++; if ({wb_data.res_time_start, wb_data.res_time_end} !== 64'd0) begin errors++; $display("FAIL nm_res: got %0d/%0d, expected 0/0", wb_data.res_time_start, wb_data.res_time_end); end
        checks++; if (prev_end !== 32'd0) begin errors++; $display("FAIL nm_prev_before: got %0d, expected 0", prev_end); end
        accept();
        checks++; if (prev_end !== 32'd103) begin errors++; $display("FAIL nm_prev_after: got %0d, expected 103", prev_end); end
    endtask

    task automatic test_mem();
        push_elem(mk(1'b0, 1'b1, 32'd190, 32'd200));
        pulse_evt(32'd200, 1'b0, 1'b1);
        pulse_evt(32'd202, 1'b1, 1'b0);
        pulse_evt(32'd204, 1'b0, 1'b1);
        wait_valid(8, "mem_valid");
        checks++; if (wb_data.wb_time_start !== 32'd201) begin errors++; $display("FAIL mem_wb_start: got %0d, expected 201", wb_data.wb_time_start); end
        checks++; if (wb_data.res_time_start !== 32'd201) begin errors++; $display("FAIL mem_res_start: got %0d, expected 201", wb_data.res_time_start); end
        checks++; if (wb_data.wb_time_end !== 32'd204) begin errors++; $display("FAIL mem_wb_end: got %0d, expected 204", wb_data.wb_time_end); end
        checks++; if (wb_data.res_time_end !== 32'd204) begin errors++; $display("FAIL mem_res_end: got %0d, expected 204", wb_data.res_time_end); end
        accept();
        checks++; if (prev_end !== 32'd204) begin errors++; $display("FAIL mem_prev_end: got %0d, expected 204", prev_end); end
    endtask

    task automatic test_simultaneous();
        push_elem(mk(1'b0, 1'b0, 32'd300, 32'd0));
        push_elem(mk(1'b0, 1'b1, 32'd0, 32'd300));
        pulse_evt(32'd305, 1'b1, 1'b1);
        wait_valid(8, "sim_first_valid");
        checks++; if (wb_data.is_mem !== 1'b0 || wb_data.wb_time_end !== 32'd305) begin errors++; $display("FAIL sim_first: is_mem=%b end=%0d, expected 0/305", wb_data.is_mem, wb_data.wb_time_end); end
        accept();
        repeat (6) @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sim_single_use: wb_valid=%b, expected 0", wb_valid); end
        checks++; if (state !== ST_SEARCH) begin errors++; $display("FAIL sim_wait_state: got %0d, expected %0d", state, ST_SEARCH); end
        pulse_evt(32'd310, 1'b0, 1'b1);
        wait_valid(6, "sim_second_valid");
        checks++; if (wb_data.wb_time_start !== 32'd301 || wb_data.wb_time_end !== 32'd310) begin errors++; $display("FAIL sim_second: got %0d..%0d, expected 301..310", wb_data.wb_time_start, wb_data.wb_time_end); end
        accept();
    endtask

    task automatic test_back_to_back();
        int seen, t_first, t_second;
        seen = 0; t_first = 0; t_second = 0;
        dn_ready = 1'b1;
        push_elem(mk(1'b1, 1'b0, 32'd1, 32'd0));
        push_elem(mk(1'b1, 1'b0, 32'd2, 32'd0));
        for (int i = 0; i < 12; i++) begin
            if (wb_valid === 1'b1) begin
                if (seen == 0) t_first = i;
                else if (seen == 1) t_second = i;
                seen++;
            end
            @(negedge clk);
        end
        dn_ready = 1'b0;
        checks++; if (seen != 2) begin errors++; $display("FAIL b2b_count: got %0d emitted cycles, expected 2", seen); end
        checks++; if (t_second - t_first != 3) begin errors++; $display("FAIL b2b_spacing: got %0d cycles, expected 3", t_second - t_first); end
    endtask

    task automatic test_wrap();
        ex_data   = mk(1'b0, 1'b0, 32'd250, 32'd0);
        ex_valid8 = 1'b1;
        @(negedge clk);
        ex_valid8 = 1'b0;
        counter8  = 8'd249;
        wb_ready8 = 1'b1;
        @(negedge clk);
        counter8  = 8'd3;
        @(negedge clk);
        wb_ready8 = 1'b0;
        for (int n = 0; n < 10 && wb_valid8 !== 1'b1; n++) @(negedge clk);
        checks++; if (wb_valid8 !== 1'b1) begin errors++; $display("FAIL wrap_valid: got %b, expected 1", wb_valid8); end
        checks++; if (wb_data8.wb_time_end !== 32'd3 || wb_data8.wb_time_start !== 32'd3) begin errors++; $display("FAIL wrap_time: got %0d..%0d, expected 3..3", wb_data8.wb_time_start, wb_data8.wb_time_end); end
        dn_ready8 = 1'b1;
        @(negedge clk);
        dn_ready8 = 1'b0;
        checks++; if (prev_end8 !== 8'd3) begin errors++; $display("FAIL wrap_prev_end: got %0d, expected 3", prev_end8); end
    endtask

    task automatic test_backpressure();
        wb_trace_t p;
        p = mk(1'b1, 1'b0, 32'h1234, 32'd0);
        p.wb_time_end = 32'hABCD;
        push_elem(p);
        repeat (2) @(negedge clk);
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, expected 1", wb_valid); end
        for (int k = 1; k <= 40; k++) begin
            counter  = 32'(k);
            wb_ready = 1'b1;
            ex_data  = mk(1'b1, 1'b0, 32'(k + 1000), 32'd0);
            ex_valid = 1'b1;
            @(negedge clk);
            checks++; if (wb_valid !== 1'b1 || wb_data !== p) begin errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%h, expected 1/%h", k, wb_valid, wb_data, p); end
            checks++; if (ovf !== (k > 16)) begin errors++; $display("FAIL bp_overflow[%0d]: got %b, expected %b", k, ovf, (k > 16)); end
            checks++; if (ex_ready !== (k < TRACE_DEPTH)) begin errors++; $display("FAIL bp_ex_ready[%0d]: got %b, expected %b", k, ex_ready, (k < TRACE_DEPTH)); end
        end
        wb_ready = 1'b0;
        ex_valid = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        #2 rst = 1'b0;
        #1;
        checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rop_ex_ready: got %b, expected 1", ex_ready); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rop_wb_valid: got %b, expected 0", wb_valid); end
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL rop_wb_data: got %h, expected 0", wb_data); end
        checks++; if (prev_end !== 32'd0) begin errors++; $display("FAIL rop_prev_end: got %0d, expected 0", prev_end); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rop_overflow: got %b, expected 0", ovf); end
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rop_flushed: wb_valid=%b, expected 0", wb_valid); end
    endtask

    task automatic test_reset_mid_search();
        wb_trace_t p;
        push_elem(mk(1'b0, 1'b0, 32'd500, 32'd0));
        repeat (2) @(negedge clk);
        checks++; if (state !== ST_SEARCH) begin errors++; $display("FAIL rs_in_search: got %0d, expected %0d", state, ST_SEARCH); end
        #2 rst = 1'b0;
        #1;
        checks++; if (wb_data !== '0) begin errors++; $display("FAIL rs_wb_data: got %h, expected 0", wb_data); end
        checks++; if (state !== ST_IDLE || wb_valid !== 1'b0) begin errors++; $display("FAIL rs_state: state=%0d valid=%b, expected %0d/0", state, wb_valid, ST_IDLE); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        p = mk(1'b1, 1'b0, 32'd77, 32'd0);
        push_elem(p);
        @(negedge clk);
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rs_pt_early: wb_valid=%b, expected 0", wb_valid); end
        @(negedge clk);
        checks++; if (wb_valid !== 1'b1 || wb_data !== p) begin errors++; $display("FAIL rs_pt_emit: valid=%b data=%h, expected 1/%h", wb_valid, wb_data, p); end
        accept();
    endtask

    initial begin
        test_reset();
        test_pass_through();
        test_non_mem();
        test_mem();
        test_simultaneous();
        test_back_to_back();
        test_wrap();
        test_backpressure();
        test_reset_mid_op();
        test_reset_mid_search();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
